// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time trial controller.
package reaction_pkg;

  localparam int unsigned LFSR_W     = 16;
  localparam int unsigned BCD_W      = 16;
  localparam int unsigned WAIT_CNT_W = 17;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_EARLY = 3'd4
  } state_t;

  localparam logic [BCD_W-1:0]  BCD_MAX   = 16'h9999;
  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bcd_counter_4d.sv
// Four-digit BCD up-counter; clear wins over increment, saturates at 9999.
module bcd_counter_4d
  import reaction_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             at_max
);

  logic [BCD_W-1:0] q_inc;
  logic             carry;

  // Ripple the +1 through the digits, wrapping 9 -> 0
  always_comb begin
    q_inc = q;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (q[4*i +: 4] == 4'd9) begin
          q_inc[4*i +: 4] = 4'd0;
        end else begin
          q_inc[4*i +: 4] = q[4*i +: 4] + 4'd1;
          carry           = 1'b0;
        end
      end
    end
  end

  assign at_max = (q == BCD_MAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !at_max) begin
      q <= q_inc;
    end
  end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-time trial controller: random GO delay, then BCD ms count until react.
module reaction_timer_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned       WAIT_MIN_MS     = 1000,
  parameter int unsigned       WAIT_RANGE_BITS = 11,
  parameter logic [LFSR_W-1:0] LFSR_SEED       = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ms_tick,
  input  logic             start,
  input  logic             react,
  output logic             timer_en,
  output logic             led_go,
  output logic [BCD_W-1:0] bcd_ms,
  output logic             done,
  output logic             early,
  output logic             overflow
);

  localparam logic [LFSR_W-1:0] RANGE_MASK = LFSR_W'((32'd1 << WAIT_RANGE_BITS) - 32'd1);

  state_t                  state, state_nxt;
  logic [WAIT_CNT_W-1:0]   wait_cnt, wait_cnt_nxt, wait_load;
  logic [LFSR_W-1:0]       lfsr;
  logic                    tick_q;
  logic                    timer_en_nxt, led_go_nxt, done_nxt, early_nxt, overflow_nxt;
  logic                    bcd_clr, bcd_inc, bcd_at_max;

  // Tick source may idle high while disabled, so gate it with our own enable
  assign tick_q    = ms_tick & timer_en;
  assign wait_load = WAIT_CNT_W'(WAIT_MIN_MS) + WAIT_CNT_W'(lfsr & RANGE_MASK);

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      timer_en <= 1'b0;
      led_go   <= 1'b0;
      done     <= 1'b0;
      early    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      timer_en <= timer_en_nxt;
      led_go   <= led_go_nxt;
      done     <= done_nxt;
      early    <= early_nxt;
      overflow <= overflow_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_EARLY: begin
        if (start) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (react)                                 state_nxt = ST_EARLY;
        else if (tick_q && wait_cnt == 17'd1)      state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (react)                                 state_nxt = ST_DONE;
        else if (tick_q && bcd_at_max)             state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values for registered outputs and the counter controls
  always_comb begin
    timer_en_nxt = timer_en;
    led_go_nxt   = led_go;
    done_nxt     = done;
    early_nxt    = early;
    overflow_nxt = overflow;
    wait_cnt_nxt = wait_cnt;
    bcd_clr      = 1'b0;
    bcd_inc      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_EARLY: begin
        if (start) begin
          wait_cnt_nxt = wait_load;
          bcd_clr      = 1'b1;
          done_nxt     = 1'b0;
          early_nxt    = 1'b0;
          overflow_nxt = 1'b0;
          led_go_nxt   = 1'b0;
          timer_en_nxt = 1'b1;
        end
      end
      ST_WAIT: begin
        if (react) begin
          early_nxt    = 1'b1;
          timer_en_nxt = 1'b0;
          led_go_nxt   = 1'b0;
        end else if (tick_q) begin
          wait_cnt_nxt = wait_cnt - 17'd1;
          if (wait_cnt == 17'd1) led_go_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (react) begin
          done_nxt     = 1'b1;
          led_go_nxt   = 1'b0;
          timer_en_nxt = 1'b0;
        end else if (tick_q) begin
          if (bcd_at_max) begin
            done_nxt     = 1'b1;
            overflow_nxt = 1'b1;
            led_go_nxt   = 1'b0;
            timer_en_nxt = 1'b0;
          end else begin
            bcd_inc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  bcd_counter_4d u_bcd (
    .clk    (clk),
    .rst    (rst),
    .clr    (bcd_clr),
    .inc    (bcd_inc),
    .q      (bcd_ms),
    .at_max (bcd_at_max)
  );

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed self-checking bench for reaction_timer_ctrl (WAIT_MIN_MS=3, WAIT_RANGE_BITS=2).
module tb_reaction_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ms_tick;
  logic        start;
  logic        react;
  logic        timer_en;
  logic        led_go;
  logic [15:0] bcd_ms;
  logic        done;
  logic        early;
  logic        overflow;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] m_lfsr;
  int          exp_wait;
  int          go_cnt;

  always #10 clk = ~clk;

  reaction_timer_ctrl #(
    .WAIT_MIN_MS     (3),
    .WAIT_RANGE_BITS (2),
    .LFSR_SEED       (16'hACE1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ms_tick  (ms_tick),
    .start    (start),
    .react    (react),
    .timer_en (timer_en),
    .led_go   (led_go),
    .bcd_ms   (bcd_ms),
    .done     (done),
    .early    (early),
    .overflow (overflow)
  );

  // Reference LFSR: x^16 + x^14 + x^13 + x^11, shifting every non-reset edge
  always @(posedge clk) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic logic [15:0] to_bcd(input int n);
    return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One ms from the tick stub: 9 quiet clocks then a 1-clock pulse
  task automatic tick();
    ms_tick = 1'b0;
    cyc(9);
    ms_tick = 1'b1;
    cyc(1);
    ms_tick = 1'b0;
  endtask

  task automatic do_start();
    exp_wait = 3 + int'(m_lfsr[1:0]);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  // Advance until GO lights (bounded); fast = ms_tick already held high by caller
  task automatic wait_go(input bit fast, output int cnt);
    cnt = 0;
    while (!led_go && cnt < 40) begin
      if (fast) cyc(1);
      else      tick();
      cnt++;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_out"}, {26'd0, timer_en, led_go, done, early, overflow, |bcd_ms}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; ms_tick = 1'b0; start = 1'b0; react = 1'b0;

    // 1: reset, then stale ticks while disabled
    cyc(2);
    chk_idle("reset");
    chk("reset_bcd", 32'(bcd_ms), 32'h0);
    rst = 1'b1;
    ms_tick = 1'b1;
    cyc(5);
    ms_tick = 1'b0;
    chk_idle("stale_tick");

    // 2: normal trial, react after 42 RUN ticks
    do_start();
    chk("t2_timer_en", 32'(timer_en), 32'd1);
    chk("t2_led_off", 32'(led_go), 32'd0);
    wait_go(1'b0, go_cnt);
    chk("t2_go_delay", 32'(go_cnt), 32'(exp_wait));
    chk("t2_led_on", 32'(led_go), 32'd1);
    chk("t2_bcd_start", 32'(bcd_ms), 32'h0);
    repeat (42) tick();
    chk("t2_bcd42_run", 32'(bcd_ms), 32'h0042);
    react = 1'b1;
    cyc(1);
    react = 1'b0;
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_bcd", 32'(bcd_ms), 32'h0042);
    chk("t2_led", 32'(led_go), 32'd0);
    chk("t2_timer_en_off", 32'(timer_en), 32'd0);
    chk("t2_flags", {30'd0, early, overflow}, 32'd0);
    react = 1'b1;
    tick();
    react = 1'b0;
    chk("t2_hold", {15'd0, done, bcd_ms}, {15'd0, 1'b1, 16'h0042});

    // 3/6a: restart from DONE, then false start on 1st WAIT tick
    do_start();
    chk("t6_restart_bcd", 32'(bcd_ms), 32'h0);
    chk("t6_restart_flags", {29'd0, done, early, timer_en}, 32'd1);
    ms_tick = 1'b0;
    cyc(9);
    ms_tick = 1'b1;
    react = 1'b1;
    cyc(1);
    ms_tick = 1'b0;
    react = 1'b0;
    chk("t3_early", 32'(early), 32'd1);
    chk("t3_done", 32'(done), 32'd0);
    chk("t3_timer_en", 32'(timer_en), 32'd0);
    repeat (6) tick();
    chk("t3_no_go", {15'd0, led_go, bcd_ms}, 32'h0);
    chk("t3_early_hold", 32'(early), 32'd1);

    // 4: no react, carry through every digit then saturate
    ms_tick = 1'b1;
    do_start();
    wait_go(1'b1, go_cnt);
    chk("t4_go_delay", 32'(go_cnt), 32'(exp_wait));
    for (int n = 1; n <= 10000; n++) begin
      cyc(1);
      if (n == 9 || n == 10 || n == 99 || n == 100 || n == 999 || n == 1000 ||
          n == 9999)
        chk($sformatf("t4_bcd_%0d", n), 32'(bcd_ms), 32'(to_bcd(n)));
      if (n == 9999) chk("t4_not_done", 32'(done), 32'd0);
    end
    ms_tick = 1'b0;
    chk("t4_sat_bcd", 32'(bcd_ms), 32'h9999);
    chk("t4_done_ovf", {30'd0, done, overflow}, 32'd3);
    chk("t4_off", {30'd0, timer_en, led_go}, 32'd0);

    // 5: react coincides with a tick at 0007; start ignored in RUN
    do_start();
    chk("t5_restart_bcd", 32'(bcd_ms), 32'h0);
    wait_go(1'b0, go_cnt);
    chk("t5_go_delay", 32'(go_cnt), 32'(exp_wait));
    repeat (7) tick();
    chk("t5_bcd7", 32'(bcd_ms), 32'h0007);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("t5_start_ignored", {14'd0, led_go, timer_en, bcd_ms}, {14'd0, 2'b11, 16'h0007});
    ms_tick = 1'b1;
    react = 1'b1;
    cyc(1);
    ms_tick = 1'b0;
    react = 1'b0;
    chk("t5_bcd_final", 32'(bcd_ms), 32'h0007);
    chk("t5_done_ovf", {30'd0, done, overflow}, 32'd2);

    // 6b: reset mid-RUN, then a fresh trial
    do_start();
    wait_go(1'b0, go_cnt);
    repeat (3) tick();
    chk("t6_running", 32'(bcd_ms), 32'h0003);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    chk_idle("t6_reset");
    do_start();
    wait_go(1'b0, go_cnt);
    chk("t6_go_delay", 32'(go_cnt), 32'(exp_wait));
    repeat (5) tick();
    react = 1'b1;
    cyc(1);
    react = 1'b0;
    chk("t6_after_reset", {15'd0, done, bcd_ms}, {15'd0, 1'b1, 16'h0005});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
